// File: rtl/tile_core_req_buffer_if.sv
// Bundle of the core-side and crossbar-side signals of tile_core_req_buffer.
// The "slave" modport is the buffer's view; "master" is the view of the
// environment (core plus crossbar) driving it.
interface tile_core_req_buffer_if #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4
);
    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned CntWidth = $clog2(MaxOutstanding) + 1;

    // Core request side
    logic                 core_req_valid_i;
    logic                 core_req_ready_o;
    logic [AddrWidth-1:0] core_req_addr_i;
    logic                 core_req_wen_i;
    logic [DataWidth-1:0] core_req_wdata_i;
    logic [BeWidth-1:0]   core_req_be_i;

    // Core response side
    logic                 core_rsp_valid_o;
    logic                 core_rsp_ready_i;
    logic [DataWidth-1:0] core_rsp_rdata_o;

    // Crossbar side
    logic                 xbar_req_o;
    logic [AddrWidth-1:0] xbar_addr_o;
    logic                 xbar_wen_o;
    logic [DataWidth-1:0] xbar_wdata_o;
    logic [BeWidth-1:0]   xbar_be_o;
    logic                 xbar_gnt_i;
    logic                 xbar_vld_i;
    logic [DataWidth-1:0] xbar_rdata_i;

    // Credit count
    logic [CntWidth-1:0]  outstanding_o;

    modport slave (
        input  core_req_valid_i, core_req_addr_i, core_req_wen_i,
               core_req_wdata_i, core_req_be_i, core_rsp_ready_i,
               xbar_gnt_i, xbar_vld_i, xbar_rdata_i,
        output core_req_ready_o, core_rsp_valid_o, core_rsp_rdata_o,
               xbar_req_o, xbar_addr_o, xbar_wen_o, xbar_wdata_o, xbar_be_o,
               outstanding_o
    );

    modport master (
        output core_req_valid_i, core_req_addr_i, core_req_wen_i,
               core_req_wdata_i, core_req_be_i, core_rsp_ready_i,
               xbar_gnt_i, xbar_vld_i, xbar_rdata_i,
        input  core_req_ready_o, core_rsp_valid_o, core_rsp_rdata_o,
               xbar_req_o, xbar_addr_o, xbar_wen_o, xbar_wdata_o, xbar_be_o,
               outstanding_o
    );
endinterface

// File: rtl/tile_core_req_buffer.sv
// tile_core_req_buffer: one-entry request register towards the tile crossbar,
// credit-limited outstanding transactions and an in-order response FIFO.
// Optional feature macro: TILE_REQ_BUF_RSP_BYPASS_EN -- when defined, a
// crossbar response arriving while the FIFO is empty is presented to the core
// combinationally in the same cycle (and only stored if the core stalls).
// SpuriousFatal selects whether a dropped spurious xbar_vld_i stops simulation.
module tile_core_req_buffer #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter bit          SpuriousFatal  = 1'b1
) (
    input logic                   clk_i,
    input logic                   rst_i,
    tile_core_req_buffer_if.slave bus
);
    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned CntWidth = $clog2(MaxOutstanding) + 1;
    localparam int unsigned IdxWidth = $clog2(MaxOutstanding);
    localparam int unsigned PtrWidth = IdxWidth + 1;
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

    // Request register
    logic                 r_full;
    logic [AddrWidth-1:0] r_addr;
    logic                 r_wen;
    logic [DataWidth-1:0] r_wdata;
    logic [BeWidth-1:0]   r_be;

    // Counters
    logic [CntWidth-1:0]  r_credits;
    logic [CntWidth-1:0]  r_inflight;

    // Response FIFO
    logic [PtrWidth-1:0]  r_wptr;
    logic [PtrWidth-1:0]  r_rptr;
    logic [DataWidth-1:0] r_mem [MaxOutstanding];

    logic                 w_grant;
    logic                 w_req_ready;
    logic                 w_accept;
    logic                 w_spurious;
    logic                 w_rsp_ok;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_fifo_pop;
    logic                 w_rsp_valid;
    logic [DataWidth-1:0] w_rsp_rdata;
    logic                 w_core_pop;
    logic [IdxWidth-1:0]  w_widx;
    logic [IdxWidth-1:0]  w_ridx;

    assign w_grant     = r_full && bus.xbar_gnt_i;
    // Ready only looks at the register and the credits, never at the
    // response handshake, so no path exists from core_rsp_ready_i to here.
    assign w_req_ready = (!r_full || bus.xbar_gnt_i) && (r_credits < MaxCnt);
    assign w_accept    = bus.core_req_valid_i && w_req_ready;
    assign w_spurious  = bus.xbar_vld_i && (r_inflight == '0);
    assign w_rsp_ok    = bus.xbar_vld_i && !w_spurious;

    assign w_widx  = r_wptr[IdxWidth-1:0];
    assign w_ridx  = r_rptr[IdxWidth-1:0];
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (w_widx == w_ridx) && (r_wptr[PtrWidth-1] != r_rptr[PtrWidth-1]);

`ifdef TILE_REQ_BUF_RSP_BYPASS_EN
    // Empty FIFO: the crossbar response is forwarded directly and stored
    // only when the core is not taking it this cycle.
    assign w_rsp_valid = !w_empty || w_rsp_ok;
    assign w_rsp_rdata = !w_empty ? r_mem[w_ridx]
                       : (w_rsp_ok ? bus.xbar_rdata_i : '0);
    assign w_push      = w_rsp_ok && !(w_empty && bus.core_rsp_ready_i);
    assign w_fifo_pop  = !w_empty && bus.core_rsp_ready_i;
`else
    // Every response is stored first; the core only ever sees FIFO state.
    assign w_rsp_valid = !w_empty;
    assign w_rsp_rdata = w_empty ? '0 : r_mem[w_ridx];
    assign w_push      = w_rsp_ok;
    assign w_fifo_pop  = !w_empty && bus.core_rsp_ready_i;
`endif

    assign w_core_pop = w_rsp_valid && bus.core_rsp_ready_i;

    assign bus.core_req_ready_o = w_req_ready;
    assign bus.core_rsp_valid_o = w_rsp_valid;
    assign bus.core_rsp_rdata_o = w_rsp_rdata;
    assign bus.xbar_req_o       = r_full;
    assign bus.xbar_addr_o      = r_addr;
    assign bus.xbar_wen_o       = r_wen;
    assign bus.xbar_wdata_o     = r_wdata;
    assign bus.xbar_be_o        = r_be;
    assign bus.outstanding_o    = r_credits;

    // Request register: load on accept (also in the grant cycle), free on grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_full  <= 1'b0;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_full  <= 1'b1;
            r_addr  <= bus.core_req_addr_i;
            r_wen   <= bus.core_req_wen_i;
            r_wdata <= bus.core_req_wdata_i;
            r_be    <= bus.core_req_be_i;
        end else if (w_grant) begin
            r_full  <= 1'b0;
        end
    end

    // Credits cover register + in-flight + FIFO, bounding FIFO occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_credits <= '0;
        end else begin
            case ({w_accept, w_core_pop})
                2'b10:   r_credits <= r_credits + CntWidth'(1);
                2'b01:   r_credits <= r_credits - CntWidth'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    // In-flight count: granted requests still waiting for their response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_inflight <= '0;
        end else begin
            case ({w_grant, w_rsp_ok})
                2'b10:   r_inflight <= r_inflight + CntWidth'(1);
                2'b01:   r_inflight <= r_inflight - CntWidth'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // FIFO pointers with wrap bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push)     r_wptr <= r_wptr + PtrWidth'(1);
            if (w_fifo_pop) r_rptr <= r_rptr + PtrWidth'(1);
        end
    end

    // FIFO storage, one cleared entry per slot so the read port is 0 after reset.
    generate
        for (genvar gi = 0; gi < int'(MaxOutstanding); gi++) begin : g_mem
            // Write slot gi when the write pointer addresses it.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_mem[gi] <= '0;
                end else if (w_push && (w_widx == IdxWidth'(gi))) begin
                    r_mem[gi] <= bus.xbar_rdata_i;
                end
            end
        end
    endgenerate

`ifndef SYNTHESIS
    logic                 r_chk_pend;
    logic [AddrWidth-1:0] r_chk_addr;
    logic                 r_chk_wen;
    logic [DataWidth-1:0] r_chk_wdata;
    logic [BeWidth-1:0]   r_chk_be;

    // Protocol checks: FIFO overflow, spurious responses, unstable pending request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_chk_pend  <= 1'b0;
            r_chk_addr  <= '0;
            r_chk_wen   <= 1'b0;
            r_chk_wdata <= '0;
            r_chk_be    <= '0;
        end else begin
            r_chk_pend  <= r_full && !bus.xbar_gnt_i;
            r_chk_addr  <= r_addr;
            r_chk_wen   <= r_wen;
            r_chk_wdata <= r_wdata;
            r_chk_be    <= r_be;
            if (w_push && w_full && !w_fifo_pop)
                $fatal(1, "tile_core_req_buffer: response FIFO push while full");
            if (w_spurious) begin
                if (SpuriousFatal)
                    $fatal(1, "tile_core_req_buffer: spurious xbar_vld_i");
                else
                    $warning("tile_core_req_buffer: spurious xbar_vld_i dropped");
            end
            if (r_chk_pend && ((r_addr != r_chk_addr) || (r_wen != r_chk_wen) ||
                               (r_wdata != r_chk_wdata) || (r_be != r_chk_be)))
                $fatal(1, "tile_core_req_buffer: xbar fields changed while ungranted");
        end
    end
`endif
endmodule

// File: tb/tb_tile_core_req_buffer.sv
// Directed testbench for tile_core_req_buffer (MaxOutstanding = 4).
module tb_tile_core_req_buffer;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MO = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   errors = 0;

    tile_core_req_buffer_if #(.AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)) bus ();

    tile_core_req_buffer #(
        .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO), .SpuriousFatal(1'b0)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.core_req_valid_i = 1'b0;
        bus.core_req_addr_i  = '0;
        bus.core_req_wen_i   = 1'b0;
        bus.core_req_wdata_i = '0;
        bus.core_req_be_i    = '0;
        bus.core_rsp_ready_i = 1'b0;
        bus.xbar_gnt_i       = 1'b0;
        bus.xbar_vld_i       = 1'b0;
        bus.xbar_rdata_i     = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        cyc();
        cyc();
        @(negedge clk_i);
        checks++;
        if ({bus.xbar_req_o, bus.xbar_wen_o, bus.core_rsp_valid_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got req/wen/rsp_valid=%b required 000",
                     {bus.xbar_req_o, bus.xbar_wen_o, bus.core_rsp_valid_o});
        end
        checks++;
        if ({bus.xbar_addr_o, bus.xbar_wdata_o, bus.xbar_be_o, bus.core_rsp_rdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_fields: got addr=%h wdata=%h be=%h rdata=%h required all 0",
                     bus.xbar_addr_o, bus.xbar_wdata_o, bus.xbar_be_o, bus.core_rsp_rdata_o);
        end
        cyc();
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.core_req_ready_o !== 1'b1 || bus.outstanding_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_ready: got ready=%b outstanding=%0d required ready=1 outstanding=0",
                     bus.core_req_ready_o, bus.outstanding_o);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_read();
        cyc();
        bus.core_rsp_ready_i = 1'b1;
        bus.core_req_valid_i = 1'b1;
        bus.core_req_addr_i  = 32'h100;
        bus.core_req_wen_i   = 1'b0;
        bus.core_req_be_i    = 4'hF;
        @(negedge clk_i);
        checks++;
        if (bus.core_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: got ready=%b required 1", bus.core_req_ready_o);
        end
        cyc();
        bus.core_req_valid_i = 1'b0;
        bus.xbar_gnt_i       = 1'b1;
        @(negedge clk_i);
        checks++;
        if (bus.xbar_req_o !== 1'b1 || bus.xbar_addr_o !== 32'h100 || bus.xbar_wen_o !== 1'b0 ||
            bus.outstanding_o !== 3'd1) begin
            errors++;
            $display("FAIL single_req: got req=%b addr=%h wen=%b out=%0d required 1 100 0 1",
                     bus.xbar_req_o, bus.xbar_addr_o, bus.xbar_wen_o, bus.outstanding_o);
        end
        cyc();
        bus.xbar_gnt_i   = 1'b0;
        bus.xbar_vld_i   = 1'b1;
        bus.xbar_rdata_i = 32'hDEADBEEF;
        @(negedge clk_i);
        checks++;
        if (bus.xbar_req_o !== 1'b0) begin
            errors++;
            $display("FAIL single_req_pulse: got req=%b in cycle 2 required 0", bus.xbar_req_o);
        end
`ifdef TILE_REQ_BUF_RSP_BYPASS_EN
        checks++;
        if (bus.core_rsp_valid_o !== 1'b1 || bus.core_rsp_rdata_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_rsp_c2: got valid=%b rdata=%h required 1 deadbeef",
                     bus.core_rsp_valid_o, bus.core_rsp_rdata_o);
        end
`else
        checks++;
        if (bus.core_rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp_c2: got valid=%b required 0", bus.core_rsp_valid_o);
        end
`endif
        cyc();
        bus.xbar_vld_i   = 1'b0;
        bus.xbar_rdata_i = '0;
        @(negedge clk_i);
`ifdef TILE_REQ_BUF_RSP_BYPASS_EN
        checks++;
        if (bus.core_rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp_c3: got valid=%b required 0", bus.core_rsp_valid_o);
        end
`else
        checks++;
        if (bus.core_rsp_valid_o !== 1'b1 || bus.core_rsp_rdata_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_rsp_c3: got valid=%b rdata=%h required 1 deadbeef",
                     bus.core_rsp_valid_o, bus.core_rsp_rdata_o);
        end
`endif
        cyc();
        @(negedge clk_i);
        checks++;
        if (bus.core_rsp_valid_o !== 1'b0 || bus.outstanding_o !== 3'd0) begin
            errors++;
            $display("FAIL single_done: got valid=%b out=%0d required 0 0",
                     bus.core_rsp_valid_o, bus.outstanding_o);
        end
        $display("test_single_read done");
    endtask

    task automatic test_grant_stall();
        int rsp_count = 0;
        cyc();
        bus.core_rsp_ready_i = 1'b1;
        bus.core_req_valid_i = 1'b1;
        bus.core_req_addr_i  = 32'h200;
        bus.core_req_wen_i   = 1'b1;
        bus.core_req_wdata_i = 32'hA5A5A5A5;
        bus.core_req_be_i    = 4'hF;
        cyc();
        bus.core_req_valid_i = 1'b0;
        bus.core_req_wdata_i = '0;
        bus.core_req_addr_i  = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checks++;
            if (bus.xbar_req_o !== 1'b1 || bus.xbar_addr_o !== 32'h200 || bus.xbar_wen_o !== 1'b1 ||
                bus.xbar_wdata_o !== 32'hA5A5A5A5 || bus.xbar_be_o !== 4'hF ||
                bus.core_req_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got req=%b addr=%h wen=%b wdata=%h be=%h ready=%b required 1 200 1 a5a5a5a5 f 0",
                         i, bus.xbar_req_o, bus.xbar_addr_o, bus.xbar_wen_o, bus.xbar_wdata_o,
                         bus.xbar_be_o, bus.core_req_ready_o);
            end
            cyc();
        end
        bus.xbar_gnt_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (bus.core_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_grant_ready: got ready=%b required 1", bus.core_req_ready_o);
        end
        cyc();
        bus.xbar_gnt_i   = 1'b0;
        bus.xbar_vld_i   = 1'b1;
        bus.xbar_rdata_i = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (bus.core_rsp_valid_o === 1'b1 && bus.core_rsp_ready_i === 1'b1) rsp_count++;
            cyc();
            bus.xbar_vld_i = 1'b0;
        end
        @(negedge clk_i);
        checks++;
        if (rsp_count != 1 || bus.outstanding_o !== 3'd0) begin
            errors++;
            $display("FAIL stall_response: got responses=%0d out=%0d required 1 0",
                     rsp_count, bus.outstanding_o);
        end
        $display("test_grant_stall done");
    endtask

    task automatic test_credit_limit();
        int   accepted = 0;
        int   idx = 0;
        logic prev_grant = 1'b0;
        cyc();
        bus.core_rsp_ready_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.core_req_valid_i = (c < 6);
            bus.core_req_addr_i  = 32'h300 + 32'(4 * c);
            bus.core_req_wen_i   = 1'b0;
            bus.xbar_gnt_i       = 1'b1;
            bus.xbar_vld_i       = prev_grant;
            bus.xbar_rdata_i     = 32'hC0DE0000 + 32'(idx);
            if (prev_grant) idx++;
            @(negedge clk_i);
            if (bus.core_req_valid_i && bus.core_req_ready_o) accepted++;
            prev_grant = bus.xbar_req_o && bus.xbar_gnt_i;
            cyc();
        end
        bus.core_req_valid_i = 1'b0;
        bus.xbar_gnt_i       = 1'b0;
        bus.xbar_vld_i       = 1'b0;
        @(negedge clk_i);
        checks++;
        if (accepted != 4 || bus.outstanding_o !== 3'd4 || bus.core_req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL credit_limit: got accepted=%0d out=%0d ready=%b required 4 4 0",
                     accepted, bus.outstanding_o, bus.core_req_ready_o);
        end
        cyc();
        bus.core_rsp_ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (bus.core_rsp_valid_o !== 1'b1 || bus.core_rsp_rdata_o !== 32'hC0DE0000) begin
            errors++;
            $display("FAIL credit_pop0: got valid=%b rdata=%h required 1 c0de0000",
                     bus.core_rsp_valid_o, bus.core_rsp_rdata_o);
        end
        cyc();
        bus.core_rsp_ready_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.core_req_ready_o !== 1'b1 || bus.outstanding_o !== 3'd3) begin
            errors++;
            $display("FAIL credit_return: got ready=%b out=%0d required 1 3",
                     bus.core_req_ready_o, bus.outstanding_o);
        end
        cyc();
        for (int k = 1; k < 4; k++) begin
            bus.core_rsp_ready_i = 1'b1;
            @(negedge clk_i);
            checks++;
            if (bus.core_rsp_valid_o !== 1'b1 || bus.core_rsp_rdata_o !== 32'hC0DE0000 + 32'(k)) begin
                errors++;
                $display("FAIL credit_order[%0d]: got valid=%b rdata=%h required 1 %h",
                         k, bus.core_rsp_valid_o, bus.core_rsp_rdata_o, 32'hC0DE0000 + 32'(k));
            end
            cyc();
        end
        bus.core_rsp_ready_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.outstanding_o !== 3'd0 || bus.core_rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL credit_drain: got out=%0d valid=%b required 0 0",
                     bus.outstanding_o, bus.core_rsp_valid_o);
        end
        $display("test_credit_limit done");
    endtask

    task automatic test_simultaneous();
        cyc();
        bus.core_rsp_ready_i = 1'b0;
        bus.core_req_valid_i = 1'b1;
        bus.core_req_addr_i  = 32'h400;
        cyc();
        bus.core_req_addr_i  = 32'h404;
        bus.xbar_gnt_i       = 1'b1;
        cyc();
        bus.core_req_valid_i = 1'b0;
        bus.xbar_vld_i       = 1'b1;
        bus.xbar_rdata_i     = 32'h11111111;
        cyc();
        bus.core_req_valid_i = 1'b1;
        bus.core_req_addr_i  = 32'h408;
        bus.xbar_gnt_i       = 1'b0;
        bus.xbar_vld_i       = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.outstanding_o !== 3'd2 || bus.core_rsp_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL simul_setup: got out=%0d valid=%b required 2 1",
                     bus.outstanding_o, bus.core_rsp_valid_o);
        end
        cyc();
        // accept D, grant C, response B, pop A all in this cycle
        bus.core_req_addr_i  = 32'h40C;
        bus.xbar_gnt_i       = 1'b1;
        bus.xbar_vld_i       = 1'b1;
        bus.xbar_rdata_i     = 32'h22222222;
        bus.core_rsp_ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (bus.core_req_ready_o !== 1'b1 || bus.core_rsp_rdata_o !== 32'h11111111 ||
            bus.outstanding_o !== 3'd3) begin
            errors++;
            $display("FAIL simul_cycle: got ready=%b rdata=%h out=%0d required 1 11111111 3",
                     bus.core_req_ready_o, bus.core_rsp_rdata_o, bus.outstanding_o);
        end
        cyc();
        bus.core_req_valid_i = 1'b0;
        bus.xbar_rdata_i     = 32'h33333333;
        @(negedge clk_i);
        checks++;
        if (bus.outstanding_o !== 3'd3 || bus.core_rsp_valid_o !== 1'b1 ||
            bus.core_rsp_rdata_o !== 32'h22222222) begin
            errors++;
            $display("FAIL simul_after: got out=%0d valid=%b rdata=%h required 3 1 22222222",
                     bus.outstanding_o, bus.core_rsp_valid_o, bus.core_rsp_rdata_o);
        end
        cyc();
        bus.xbar_gnt_i   = 1'b0;
        bus.xbar_rdata_i = 32'h44444444;
        @(negedge clk_i);
        checks++;
        if (bus.core_rsp_rdata_o !== 32'h33333333 || bus.outstanding_o !== 3'd2) begin
            errors++;
            $display("FAIL simul_c: got rdata=%h out=%0d required 33333333 2",
                     bus.core_rsp_rdata_o, bus.outstanding_o);
        end
        cyc();
        bus.xbar_vld_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.core_rsp_valid_o !== 1'b1 || bus.core_rsp_rdata_o !== 32'h44444444 ||
            bus.outstanding_o !== 3'd1) begin
            errors++;
            $display("FAIL simul_d: got valid=%b rdata=%h out=%0d required 1 44444444 1",
                     bus.core_rsp_valid_o, bus.core_rsp_rdata_o, bus.outstanding_o);
        end
        cyc();
        bus.core_rsp_ready_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.outstanding_o !== 3'd0 || bus.core_rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL simul_drain: got out=%0d valid=%b required 0 0",
                     bus.outstanding_o, bus.core_rsp_valid_o);
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_reset_mid();
        cyc();
        idle_inputs();
        bus.core_req_valid_i = 1'b1;
        bus.core_req_addr_i  = 32'h500;
        cyc();
        bus.xbar_gnt_i = 1'b1;
        cyc();
        cyc();
        bus.core_req_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.outstanding_o !== 3'd3) begin
            errors++;
            $display("FAIL rstmid_setup: got out=%0d required 3", bus.outstanding_o);
        end
        cyc();
        bus.xbar_gnt_i = 1'b0;
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.xbar_vld_i   = 1'b1;
            bus.xbar_rdata_i = 32'hBAD00000 + 32'(i);
            @(negedge clk_i);
            checks++;
            if (dut.w_spurious !== 1'b1 || bus.core_rsp_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_late[%0d]: got spurious=%b rsp_valid=%b required 1 0",
                         i, dut.w_spurious, bus.core_rsp_valid_o);
            end
            cyc();
        end
        bus.xbar_vld_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.core_rsp_valid_o !== 1'b0 || bus.outstanding_o !== 3'd0 || bus.xbar_req_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_final: got valid=%b out=%0d req=%b required 0 0 0",
                     bus.core_rsp_valid_o, bus.outstanding_o, bus.xbar_req_o);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_grant_stall();
        test_credit_limit();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tile_core_req_buffer.md
# tile_core_req_buffer

Decoupling buffer between a core's data port and the core-side data interface of the tile crossbar. It registers every core request before it reaches the crossbar and limits the number of outstanding transactions with a credit counter. It also queues crossbar responses in an in-order FIFO, so the core can apply backpressure on responses while the crossbar returns them fire-and-forget.

## Interface
Parameters:
- MaxOutstanding, 4: maximum accepted-but-not-returned transactions; power of two, at least 2; also the response FIFO depth.
- Data, address and byte-enable types are `addr_t`, `data_t` and `be_t` from `mempool_pkg`.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- core_req_valid_i  in  1  core request valid.
- core_req_ready_o  out  1  buffer accepts a core request.
- core_req_addr_i  in  addr_t  byte address.
- core_req_wen_i  in  1  1 = write.
- core_req_wdata_i  in  data_t  write data.
- core_req_be_i  in  be_t  byte enables.
- core_rsp_valid_o  out  1  response available.
- core_rsp_ready_i  in  1  core takes the response.
- core_rsp_rdata_o  out  data_t  response data; undefined for writes.
- xbar_req_o  out  1  request to the crossbar core port.
- xbar_addr_o, xbar_wen_o, xbar_wdata_o, xbar_be_o  out  as core side  registered request fields.
- xbar_gnt_i  in  1  crossbar grant.
- xbar_vld_i  in  1  crossbar response valid; exactly one per granted request, reads and writes alike.
- xbar_rdata_i  in  data_t  crossbar response data.
- outstanding_o  out  $clog2(MaxOutstanding)+1  current credit count.

## Operation
- **Request register (one entry).**
  - Loaded on `core_req_valid_i && core_req_ready_o`.
  - `xbar_req_o` is the register-full flag. All `xbar_*` fields are held stable while `xbar_req_o=1` and `xbar_gnt_i=0`.
  - Freed on `xbar_gnt_i`. It can be refilled in the same cycle.
- **Ready.** `core_req_ready_o = (!reg_full || xbar_gnt_i) && (credits < MaxOutstanding)`.
  - Ready never depends on `core_rsp_ready_i`. This avoids a combinational path from the response side to the request side.
- **Credit counter** (`outstanding_o`).
  - +1 on core accept; −1 on core response pop; unchanged when both happen in one cycle.
  - It counts the register, in-flight requests and FIFO entries together, so the FIFO can never overflow.
- **In-flight counter.**
  - +1 on `xbar_req_o && xbar_gnt_i`; −1 on `xbar_vld_i`.
  - A `xbar_vld_i` that arrives while in-flight == 0 is spurious. It is dropped: not pushed, and counters unchanged.
- **Response FIFO.**
  - Depth MaxOutstanding; circular read/write pointers with a wrap bit.
  - Push on a valid `xbar_vld_i` with `xbar_rdata_i`. Pop on `core_rsp_valid_o && core_rsp_ready_i`.
  - Push and pop in the same cycle are both performed, including when the FIFO is full-minus-one or has one entry.
  - Responses return in acceptance order, because the crossbar returns in order for a single core.
- **Simulation checks** (translate_off): fatal on a FIFO push while full, on a spurious `xbar_vld_i`, and on a change of `xbar_*` fields while the request is pending and ungranted.

## Timing
- **Reset.** Every output is 0: `xbar_req_o`, all `xbar_*` fields, `core_rsp_valid_o`, `core_rsp_rdata_o`, `outstanding_o`. `core_req_ready_o` is 1 in the first cycle after reset.
- **Reset mid-operation.**
  - Register, FIFO and both counters are cleared; pending requests and responses are lost.
  - Late `xbar_vld_i` after reset counts as spurious and is dropped.
- **Minimum latency.**
  - Accept at cycle 0.
  - `xbar_req_o=1` at cycle 1; the crossbar grants at cycle 1.
  - `xbar_vld_i` at cycle 2.
  - `core_rsp_valid_o` at cycle 3 (FIFO registered), or cycle 2 with bypass (see Configuration).
- **Throughput.** One request per cycle while grants and credits are available. It is sustained indefinitely when the core pops every cycle and round trip ≤ MaxOutstanding cycles.
- **Credits exhausted.** When credits == MaxOutstanding, `core_req_ready_o` is 0. It returns to 1 in the cycle after a pop.

## Configuration
- Macro: `TILE_REQ_BUF_RSP_BYPASS_EN`.
- **Defined.** When the FIFO is empty and `xbar_vld_i` is valid:
  - `core_rsp_valid_o=1` and `core_rsp_rdata_o=xbar_rdata_i` combinationally in the same cycle.
  - If `core_rsp_ready_i=1`, nothing is pushed; otherwise the response is pushed.
- **Undefined.** Every response passes through the FIFO, adding one cycle. There is no combinational path from `xbar_*` inputs to `core_rsp_*` outputs.

## Test plan
- **Single read.** After reset, read addr 0x100; crossbar grants immediately and returns 0xDEADBEEF. Required: `xbar_req_o` high for exactly 1 cycle; `core_rsp_rdata_o`=0xDEADBEEF at cycle 3 (cycle 2 with bypass); `outstanding_o` back to 0.
- **Grant stall.** Write 0xA5A5A5A5, be 0xF; hold `xbar_gnt_i`=0 for 5 cycles. Required: `xbar_*` fields stable for 5 cycles; `core_req_ready_o`=0 while the register is full and ungranted; one response after the grant.
- **Credit limit.** `core_rsp_ready_i`=0 and 6 back-to-back reads, MaxOutstanding=4. Required: exactly 4 accepted; `outstanding_o`=4; ready=0. After one pop, ready=1 in the next cycle; data returned in issue order.
- **Simultaneous events.** With the FIFO holding 1 entry, one cycle has a core accept, a grant, an `xbar_vld_i` and a pop together. Required: credits unchanged; FIFO count unchanged; no data loss.
- **Reset mid-operation.** Assert `rst_i` with 3 requests in flight, then inject 2 late `xbar_vld_i`. Required: no `core_rsp_valid_o`; `outstanding_o`=0; the spurious-response check fires.
